// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states (idle / shifting)
//   BCD_DIGITS     : number of BCD digits produced (hundreds, tens, ones)
//   BCD_WIDTH      : width of the BCD scratch register
//   BCD_ADJ_THRESH : digit value at or above which the add-3 correction applies
//   BCD_ADJ_ADD    : correction added to a digit before each shift
//   cnt_width()    : width of a counter that must hold the value w
package bcd_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

   localparam int unsigned BCD_DIGITS = 3;
   localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   function automatic int unsigned cnt_width(int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle of the binary-to-BCD converter.
//   start    : request a conversion (driven by the requester)
//   value    : W-bit binary operand (driven by the requester)
//   busy     : conversion in progress
//   done     : one-cycle pulse, results valid from this cycle
//   sign     : 1 = operand was negative
//   hundreds : BCD hundreds digit
//   tens     : BCD tens digit
//   ones     : BCD ones digit
//   ovf      : magnitude exceeds two digits (> 99)
// master = requester side, slave = converter side.
interface bin_to_bcd_seq_if #(
   parameter int unsigned W = 8
) ();

   logic         start;
   logic [W-1:0] value;
   logic         busy;
   logic         done;
   logic         sign;
   logic [3:0]   hundreds;
   logic [3:0]   tens;
   logic [3:0]   ones;
   logic         ovf;

   modport master (
      output start, value,
      input  busy, done, sign, hundreds, tens, ones, ovf
   );

   modport slave (
      input  start, value,
      output busy, done, sign, hundreds, tens, ones, ovf
   );

endinterface

// File: rtl/bcd_adj3.sv
// Combinational double-dabble correction cell for one BCD digit:
// adds 3 when the digit is 5 or more so the following left shift carries
// correctly into the next decimal digit.
//   digit : 4-bit BCD digit before correction
//   adj   : corrected digit
module bcd_adj3
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= BCD_ADJ_THRESH) begin
         adj = digit + BCD_ADJ_ADD;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative shift-add-3).
// A start in idle captures the magnitude and sign of value, then W shift
// cycles build three BCD digits; results are loaded with a one-cycle done
// pulse and held until the next conversion completes.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of bin_to_bcd_seq_if (start/value in, results out)
// Parameters: W (operand width, 4..9), SIGNED (1 = two's complement value).
// Build option BCD_SAT99_EN: when defined, magnitudes above 99 are shown
// as 0/9/9 (sign kept, ovf still set); otherwise true digits are shown.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter bit          SIGNED = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   bin_to_bcd_seq_if.slave bus
);

   localparam int unsigned CW = cnt_width(W);

   state_e               state_q, state_d;
   logic [W-1:0]         mag_q, mag_d;
   logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 sign_pend_q, sign_pend_d;
   logic                 done_q, done_d;
   logic                 sign_q, sign_d;
   logic                 ovf_q, ovf_d;
   logic [3:0]           hundreds_q, hundreds_d;
   logic [3:0]           tens_q, tens_d;
   logic [3:0]           ones_q, ones_d;

   logic [BCD_WIDTH-1:0]   bcd_adj;
   logic [BCD_WIDTH+W-1:0] shifted;

   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
      bcd_adj3 u_adj (
         .digit (bcd_q[4*i +: 4]),
         .adj   (bcd_adj[4*i +: 4])
      );
   end

   // Corrected digits and remaining magnitude shift as one register.
   assign shifted = {bcd_adj, mag_q} << 1;

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      bcd_d       = bcd_q;
      count_d     = count_q;
      sign_pend_d = sign_pend_q;
      done_d      = 1'b0;
      sign_d      = sign_q;
      ovf_d       = ovf_q;
      hundreds_d  = hundreds_q;
      tens_d      = tens_q;
      ones_d      = ones_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               sign_pend_d = SIGNED & bus.value[W-1];
               // Negating the most negative value wraps to itself, which is
               // still the correct unsigned magnitude (e.g. -128 -> 128).
               mag_d       = sign_pend_d ? (~bus.value + W'(1)) : bus.value;
               bcd_d       = '0;
               count_d     = CW'(W);
               state_d     = StShift;
            end
         end
         StShift: begin
            bcd_d   = shifted[BCD_WIDTH+W-1:W];
            mag_d   = shifted[W-1:0];
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               hundreds_d = bcd_d[11:8];
               tens_d     = bcd_d[7:4];
               ones_d     = bcd_d[3:0];
               sign_d     = sign_pend_q;
               ovf_d      = (bcd_d[11:8] != 4'd0);
`ifdef BCD_SAT99_EN
               if (ovf_d) begin
                  hundreds_d = 4'd0;
                  tens_d     = 4'd9;
                  ones_d     = 4'd9;
               end
`endif
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mag_q       <= '0;
         bcd_q       <= '0;
         count_q     <= '0;
         sign_pend_q <= 1'b0;
         done_q      <= 1'b0;
         sign_q      <= 1'b0;
         ovf_q       <= 1'b0;
         hundreds_q  <= 4'd0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         count_q     <= count_d;
         sign_pend_q <= sign_pend_d;
         done_q      <= done_d;
         sign_q      <= sign_d;
         ovf_q       <= ovf_d;
         hundreds_q  <= hundreds_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
      end
   end

   assign bus.busy     = (state_q == StShift);
   assign bus.done     = done_q;
   assign bus.sign     = sign_q;
   assign bus.ovf      = ovf_q;
   assign bus.hundreds = hundreds_q;
   assign bus.tens     = tens_q;
   assign bus.ones     = ones_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (W=8, SIGNED=1). Expected digits are
// hand-computed; the BCD_SAT99_EN build changes only the overflow cases.
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bin_to_bcd_seq_if #(.W(8)) bus ();

   bin_to_bcd_seq #(
      .W      (8),
      .SIGNED (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sign, hundreds, tens, ones, ovf}
   function automatic logic [14:0] res();
      return {bus.sign, bus.hundreds, bus.tens, bus.ones, bus.ovf};
   endfunction

   // Drive one start, then count edges after the accepting edge until done.
   // lat = 0 means no done within the bound.
   task automatic run_conv(input logic [7:0] v, output int lat, output int busy_bad);
      lat      = 0;
      busy_bad = 0;
      bus.value = v;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_bad++;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
         if (bus.busy !== 1'b1) busy_bad++;
         // A second start while busy must be ignored.
         bus.value = 8'h11;
         bus.start = (n == 2);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] obs;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.value = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         obs = {bus.busy, bus.done, res()};
         total++;
         if (obs !== 17'h0) begin
            bad++;
            $display("FAIL reset_idle[%0d]: got %h want 0", n, obs);
         end
      end
      // Reset wins over start on the same edge.
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.value = 8'h2A;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst_n     = 1'b1;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_prio_busy: got %b want 0", bus.busy);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_prio_idle: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_basic();
      int lat;
      int busy_bad;
      run_conv(8'h2A, lat, busy_bad);
      total++;
      if (lat !== 8) begin
         bad++;
         $display("FAIL basic_latency: got %0d edges want 8", lat);
      end
      total++;
      if (busy_bad !== 0) begin
         bad++;
         $display("FAIL basic_busy: got %0d low samples want 0", busy_bad);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy_at_done: got %b want 0", bus.busy);
      end
      total++;
      if (res() !== {1'b0, 4'd0, 4'd4, 4'd2, 1'b0}) begin
         bad++;
         $display("FAIL basic_42: got %h want %h", res(), {1'b0, 4'd0, 4'd4, 4'd2, 1'b0});
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.done !== 1'b0) begin
         bad++;
         $display("FAIL basic_done_pulse: got %b want 0", bus.done);
      end
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (res() !== {1'b0, 4'd0, 4'd4, 4'd2, 1'b0}) begin
         bad++;
         $display("FAIL basic_hold: got %h want %h", res(), {1'b0, 4'd0, 4'd4, 4'd2, 1'b0});
      end
   endtask

   task automatic test_signed();
      int lat;
      int busy_bad;
      logic [7:0]  vals [4];
      logic [14:0] exp  [4];
      vals[0] = 8'hF9; exp[0] = {1'b1, 4'd0, 4'd0, 4'd7, 1'b0};  // -7
      vals[1] = 8'h00; exp[1] = {1'b0, 4'd0, 4'd0, 4'd0, 1'b0};  // no negative zero
      vals[2] = 8'hC8; exp[2] = {1'b1, 4'd0, 4'd5, 4'd6, 1'b0};  // -56
      vals[3] = 8'hFF; exp[3] = {1'b1, 4'd0, 4'd0, 4'd1, 1'b0};  // -1
      for (int i = 0; i < 4; i++) begin
         run_conv(vals[i], lat, busy_bad);
         total++;
         if (lat !== 8 || res() !== exp[i]) begin
            bad++;
            $display("FAIL signed_%h: got lat=%0d res=%h want lat=8 res=%h",
                     vals[i], lat, res(), exp[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_overflow();
      int lat;
      int busy_bad;
      logic [7:0]  vals [3];
      logic [14:0] exp  [3];
`ifdef BCD_SAT99_EN
      vals[0] = 8'h80; exp[0] = {1'b1, 4'd0, 4'd9, 4'd9, 1'b1};
      vals[1] = 8'h7F; exp[1] = {1'b0, 4'd0, 4'd9, 4'd9, 1'b1};
      vals[2] = 8'h64; exp[2] = {1'b0, 4'd0, 4'd9, 4'd9, 1'b1};
`else
      vals[0] = 8'h80; exp[0] = {1'b1, 4'd1, 4'd2, 4'd8, 1'b1};  // -128
      vals[1] = 8'h7F; exp[1] = {1'b0, 4'd1, 4'd2, 4'd7, 1'b1};  // 127
      vals[2] = 8'h64; exp[2] = {1'b0, 4'd1, 4'd0, 4'd0, 1'b1};  // 100
`endif
      for (int i = 0; i < 3; i++) begin
         run_conv(vals[i], lat, busy_bad);
         total++;
         if (lat !== 8 || res() !== exp[i]) begin
            bad++;
            $display("FAIL ovf_%h: got lat=%0d res=%h want lat=8 res=%h",
                     vals[i], lat, res(), exp[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  vals [3];
      logic [14:0] exp  [3];
      logic        exp_done;
      vals[0] = 8'h05; exp[0] = {1'b0, 4'd0, 4'd0, 4'd5, 1'b0};
      vals[1] = 8'hC8; exp[1] = {1'b1, 4'd0, 4'd5, 4'd6, 1'b0};
      vals[2] = 8'h63; exp[2] = {1'b0, 4'd0, 4'd9, 4'd9, 1'b0};
      bus.value = vals[0];
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) bus.value = 8'hFF;  // must not disturb the conversion
            exp_done = (n == 8);
            total++;
            if (bus.done !== exp_done) begin
               bad++;
               $display("FAIL b2b_done[%0d.%0d]: got %b want %b", i, n, bus.done, exp_done);
            end
            if (n == 8) begin
               total++;
               if (res() !== exp[i]) begin
                  bad++;
                  $display("FAIL b2b_res[%0d]: got %h want %h", i, res(), exp[i]);
               end
               if (i < 2) bus.value = vals[i+1];
               else bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort();
      int lat;
      int busy_bad;
      int done_seen;
      done_seen = 0;
      bus.value = 8'h2A;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);  // 4th shift edge
      #1;
      rst_n = 1'b1;
      total++;
      if ({bus.busy, bus.done, res()} !== 17'h0) begin
         bad++;
         $display("FAIL abort_cleared: got %h want 0", {bus.busy, bus.done, res()});
      end
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0) done_seen++;
      end
      total++;
      if (done_seen !== 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d pulses want 0", done_seen);
      end
      run_conv(8'h63, lat, busy_bad);
      total++;
      if (lat !== 8 || res() !== {1'b0, 4'd0, 4'd9, 4'd9, 1'b0}) begin
         bad++;
         $display("FAIL abort_restart_99: got lat=%0d res=%h want lat=8 res=%h",
                  lat, res(), {1'b0, 4'd0, 4'd9, 4'd9, 1'b0});
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.value = 8'h00;
      test_reset();
      test_basic();
      test_signed();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).
- Sits directly upstream of the dual seven-segment decoder.
- Takes a two's-complement (or unsigned) binary value and produces a sign flag plus hundreds/tens/ones BCD digits.
- The sign flag and tens/ones digits feed the decoder's sign and digit inputs.
- Start/busy/done handshake; one conversion in flight at a time.

Parameters:
- W, 8, input width; legal range 4..9, so magnitude ≤ 511 and always fits 3 BCD digits.
- SIGNED, 1, 1 = value is two's complement; 0 = value is unsigned and sign is tied 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request conversion; sampled only in IDLE
- value  in  W  binary input, captured on the accepting edge
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse; results valid from this cycle
- sign  out  1  1 = negative input
- hundreds  out  4  BCD hundreds digit
- tens  out  4  BCD tens digit
- ones  out  4  BCD ones digit
- ovf  out  1  magnitude > 99, i.e. not representable on two digits

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; busy, done, sign, ovf = 0; hundreds, tens, ones = 0; all internal registers cleared.
  - Reset has priority over start on the same edge.
  - Reset mid-conversion aborts the conversion; no done pulse is produced.
- FSM states: IDLE, SHIFT.
  - IDLE, start=1 at edge k:
    - Capture magnitude: if SIGNED and value[W-1], mag = (~value + 1) truncated to W bits, unsigned; otherwise mag = value.
    - Capture the pending sign bit.
    - Clear the 12-bit BCD scratch; count = W; busy = 1; go to SHIFT.
  - SHIFT, each edge:
    - For each BCD scratch digit ≥ 5, add 3.
    - Then shift {bcd, mag} left by 1.
    - Decrement count.
  - On the W-th SHIFT edge (edge k+W):
    - Load hundreds, tens, ones, sign, ovf from the final scratch.
    - done = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency: W+1 cycles from the start-accepting edge to done visible (done is high in the cycle after edge k+W).
- Throughput: start may be asserted during the done cycle; it is accepted at edge k+W+1, so back-to-back period is W+1 cycles.
- start while busy is ignored; value is not re-sampled during SHIFT.
- Outputs hold their last result between conversions; they change only on the done-producing edge.
- Negative zero cannot occur: value 0 always gives sign = 0.
- W=8, SIGNED=1: -128 gives mag 128 → sign=1, 1/2/8, ovf=1.
- ovf = (hundreds != 0) | (tens, ones > 99) — equivalently hundreds != 0.

Optional Feature:
- Macro: BCD_SAT99_EN
- Defined: when magnitude > 99, the outputs saturate to tens=9, ones=9, hundreds=0, sign preserved; ovf is still asserted.
- Undefined: true digits are output, e.g. 128 → hundreds=1, tens=2, ones=8; ovf=1.
- Latency and handshake are identical in both builds.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT)
  - BCD_DIGITS = 3
  - BCD_ADJ_THRESH = 5, BCD_ADJ_ADD = 3
  - count width function clog2(W+1)
- Sub-module bcd_adj3: combinational 4-bit "if ≥5 add 3" cell, instantiated once per digit inside the shift datapath.

Test Plan:
- Reset then idle, no start → busy=0, done=0, all digits 0, sign=0, ovf=0 indefinitely.
- value=8'h2A (42), start one cycle → done exactly 9 cycles later; sign=0, 0/4/2, ovf=0; busy high for cycles 1..8 after the accepting edge.
- value=8'hF9 (-7) → sign=1, 0/0/7, ovf=0.
- value=8'h80 (-128):
  - without BCD_SAT99_EN → sign=1, 1/2/8, ovf=1.
  - with BCD_SAT99_EN → sign=1, 0/9/9, ovf=1.
- Hold start high continuously with value changing → conversions complete every 9 cycles; each result matches the value present on its accepting edge; changes to value during SHIFT are ignored.
- start accepted, then rst_n low on the 4th SHIFT edge → no done pulse; outputs 0; a new start after reset converts 8'h63 (99) → 0/9/9, ovf=0.
